// File: rtl/intr_ctrl_if.sv
// Bundles the intr_ctrl config register port, source lines and core request handshake.
interface intr_ctrl_if #(
   parameter int unsigned NUM_SRC = 4
);
   logic [NUM_SRC-1:0] src_irq;
   logic               cfg_we;
   logic [1:0]         cfg_addr;
   logic [31:0]        cfg_wdata;
   logic [31:0]        cfg_rdata;
   logic [NUM_SRC-1:0] interrupt;
   logic               intr_ack;
   logic               intr_done;
   logic               busy;

   modport master (
      output src_irq, cfg_we, cfg_addr, cfg_wdata, intr_ack, intr_done,
      input  cfg_rdata, interrupt, busy
   );

   modport slave (
      input  src_irq, cfg_we, cfg_addr, cfg_wdata, intr_ack, intr_done,
      output cfg_rdata, interrupt, busy
   );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/enable/edge registers, fixed priority, held one-hot request.
// Define INTR_TIMER_EN to build the compare timer that drives source 0.
module intr_ctrl #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TIMER_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   intr_ctrl_if.slave bus
);
   localparam int unsigned SelW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e             state_q, state_d;
   logic [SelW-1:0]    sel_q, sel_d, win_idx;
   logic [NUM_SRC-1:0] enable_q, enable_d, edge_q, edge_d, pending_q, pending_d, src_q;
   logic [NUM_SRC-1:0] interrupt_q, interrupt_d;
   logic [NUM_SRC-1:0] edge_eff, src_eff, set_vec, clr_vec, eligible;
   logic               wr_en, wr_edge, wr_pend, timer_hit;
   logic [31:0]        cmp_rd, rdata;
   logic               unused_wdata;

   assign wr_en   = bus.cfg_we && (bus.cfg_addr == 2'd0);
   assign wr_edge = bus.cfg_we && (bus.cfg_addr == 2'd1);
   assign wr_pend = bus.cfg_we && (bus.cfg_addr == 2'd2);
   assign unused_wdata = ^bus.cfg_wdata;

`ifdef INTR_TIMER_EN
   logic               wr_cmp;
   logic [TIMER_W-1:0] timer_q, timer_d, cmp_q, cmp_d;

   assign wr_cmp = bus.cfg_we && (bus.cfg_addr == 2'd3);

   always_comb begin
      timer_d = wr_cmp ? '0 : timer_q + 1'b1;
      cmp_d   = wr_cmp ? TIMER_W'(bus.cfg_wdata) : cmp_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         timer_q <= '0;
         cmp_q   <= '1;
      end else begin
         timer_q <= timer_d;
         cmp_q   <= cmp_d;
      end
   end

   // Source 0 belongs to the timer: always edge-mode, external line masked off.
   always_comb begin
      edge_eff    = edge_q;
      edge_eff[0] = 1'b1;
      src_eff     = bus.src_irq;
      src_eff[0]  = 1'b0;
   end
   assign timer_hit = (timer_q == cmp_q);
   assign cmp_rd    = 32'(cmp_q);
`else
   logic [TIMER_W-1:0] unused_timer_w;

   assign unused_timer_w = '0;
   assign edge_eff  = edge_q;
   assign src_eff   = bus.src_irq;
   assign timer_hit = 1'b0;
   assign cmp_rd    = '0;
`endif

   // A new edge outranks any clear landing on the same bit in the same cycle.
   always_comb begin
      set_vec    = src_eff & ~src_q;
      set_vec[0] = set_vec[0] | timer_hit;
      clr_vec    = '0;
      if (wr_pend) clr_vec = bus.cfg_wdata[NUM_SRC-1:0];
      if ((state_q == StReq) && bus.intr_ack) clr_vec[sel_q] = 1'b1;
      pending_d = (edge_eff & (set_vec | (pending_q & ~clr_vec))) | (~edge_eff & src_eff);
      enable_d  = wr_en   ? bus.cfg_wdata[NUM_SRC-1:0] : enable_q;
      edge_d    = wr_edge ? bus.cfg_wdata[NUM_SRC-1:0] : edge_q;
   end

   assign eligible = pending_q & enable_q;

   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) win_idx = SelW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         enable_q  <= '0;
         edge_q    <= '0;
         pending_q <= '0;
         src_q     <= '0;
      end else begin
         enable_q  <= enable_d;
         edge_q    <= edge_d;
         pending_q <= pending_d;
         src_q     <= bus.src_irq;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         interrupt_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         interrupt_q <= interrupt_d;
      end
   end

   // Ack beats a same-cycle disable, so the trap the core already took is seen through.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      unique case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d = StReq;
               sel_d   = win_idx;
            end
         end
         StReq: begin
            if (bus.intr_ack)         state_d = StService;
            else if (!enable_q[sel_q]) state_d = StIdle;
         end
         StService: begin
            if (bus.intr_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered request: computed from next state so it is a clean flop output.
   always_comb begin
      interrupt_d = '0;
      if (state_d == StReq) interrupt_d[sel_d] = 1'b1;
   end

   always_comb begin
      rdata = '0;
      unique case (bus.cfg_addr)
         2'd0: rdata[NUM_SRC-1:0] = enable_q;
         2'd1: rdata[NUM_SRC-1:0] = edge_q;
         2'd2: rdata[NUM_SRC-1:0] = pending_q;
         2'd3: rdata = cmp_rd;
         default: rdata = '0;
      endcase
   end

   assign bus.cfg_rdata = rdata;
   assign bus.interrupt = interrupt_q;
   assign bus.busy      = (state_q != StIdle);
endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that drives the core's `interrupt[3:0]` input. It latches external interrupt sources into pending bits, masks them, and selects the highest-priority request. It then presents that request as a one-hot `interrupt` vector and holds it until the core's pipeline acknowledges trap entry and later signals `mret`. A small register port lets software or a bench program the enables, the trigger modes, pending clear and an optional compare timer.

## Interface
Parameters:
- `NUM_SRC`, 4, number of interrupt sources; also the width of `interrupt`.
- `TIMER_W`, 32, width of the internal timer counter and compare register.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `src_irq` in NUM_SRC: raw source lines, already synchronous to `clk`.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 2: register select. 0 = ENABLE, 1 = EDGE (1 = edge, 0 = level), 2 = PENDING, 3 = TIMER_CMP.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: combinational read of the selected register, zero-extended.
- `interrupt` out NUM_SRC: registered one-hot request to the core.
- `intr_ack` in 1: one-cycle pulse; the core has taken the trap.
- `intr_done` in 1: one-cycle pulse; the core has executed `mret`.
- `busy` out 1: high while in REQ or SERVICE.

## Operation
- Edge detect:
  - `src_q` holds the previous sample of `src_irq`.
  - A rising edge is `src_irq & ~src_q`.
  - An edge-mode source sets its pending bit on a rising edge. The bit stays set until it is cleared by `intr_ack` or by a PENDING write-1-to-clear.
- Level mode: the pending bit is a registered copy of `src_irq`. Acks and W1C writes do not clear it.
- Eligible set = PENDING & ENABLE.
- Priority is fixed: the lowest index wins.
- FSM has three states:
  - IDLE:
    - `interrupt` = 0.
    - If the eligible set is non-zero, latch `sel` (the winning index) and go to REQ.
  - REQ:
    - `interrupt` = one-hot(`sel`).
    - On `intr_ack`, clear pending[sel] if `sel` is edge-mode, then go to SERVICE.
    - Otherwise, if ENABLE[sel] = 0, retract: go to IDLE. `intr_ack` wins over the disable when both occur in the same cycle.
  - SERVICE:
    - `interrupt` = 0.
    - New pendings accumulate but do not preempt.
    - On `intr_done`, go to IDLE.
- Pulses that arrive in the wrong state are ignored: `intr_ack` outside REQ, and `intr_done` outside SERVICE.
- Simultaneous events on the same source in the same cycle: a set (new edge) beats a clear (ack or W1C), so the pending bit stays 1.
- Register writes:
  - ENABLE and EDGE are plain writes of the low NUM_SRC bits.
  - PENDING writes are W1C for edge-mode bits only.
  - Bits at or above NUM_SRC are ignored on write and read as 0.
- Reset: `interrupt` = 0, `busy` = 0, `cfg_rdata` reflects the reset registers, ENABLE = 0, EDGE = 0, PENDING = 0, `src_q` = 0, FSM = IDLE, timer = 0, TIMER_CMP = all ones.
- A reset asserted mid-REQ or mid-SERVICE drops `interrupt` after that edge. No pending state survives.

## Timing
- Latency from a source edge to the request:
  - `src_irq` rises before edge k, so pending is set after edge k.
  - FSM moves to REQ at edge k+1, so `interrupt` is high after edge k+1.
  - Total: 2 cycles.
- `interrupt` falls on the edge that samples `intr_ack` high.
- Back-to-back service: a new request can assert no earlier than 2 cycles after `intr_done` is sampled (IDLE for one cycle, then REQ).
- A register write takes effect after the write edge; a write to ENABLE in cycle k is seen by the FSM at edge k+1.

## Configuration
- `INTR_TIMER_EN` defined:
  - A free-running TIMER_W counter increments every cycle and wraps at all ones to 0.
  - When the counter equals TIMER_CMP, pending[0] is set as an edge event. Source 0 is forced to edge mode and `src_irq[0]` is ignored.
  - A write to address 3 loads TIMER_CMP and also clears the counter.
  - A read of address 3 returns TIMER_CMP.
- `INTR_TIMER_EN` undefined:
  - No counter is built and source 0 is an ordinary external line.
  - Address 3 reads 0 and writes are ignored.

## Test plan
- **Single edge request.** ENABLE = 0xF, EDGE = 0xF, pulse `src_irq[2]` for 1 cycle.
  - `interrupt` = 4'b0100 exactly 2 cycles later.
  - `intr_ack` gives `interrupt` = 0 and pending[2] = 0.
  - `intr_done` returns the FSM to IDLE.
- **Priority and no preemption.** Raise sources 3 and 1 in the same cycle.
  - `interrupt` = 4'b0010.
  - During SERVICE, raise source 0: `interrupt` stays 0 until `intr_done`, then becomes 4'b0001.
- **Level mode re-request.** EDGE = 0, hold `src_irq[1]` high through ack and done.
  - `interrupt` = 4'b0010 again 2 cycles after `intr_done`.
  - W1C to PENDING has no effect.
- **Mask retract and collision.**
  - Clear ENABLE[2] while in REQ with `sel` = 2: `interrupt` drops to 0 in the next cycle.
  - Repeat with `intr_ack` in the same cycle as the mask write: the FSM enters SERVICE.
  - Repeat with a new edge on the source in the same cycle as a W1C clear: pending stays 1.
- **Reset mid-service.** Drive `rst` = 0 for 1 cycle while in SERVICE.
  - All outputs are 0 and PENDING = 0 after that edge.
  - `intr_done` afterwards has no effect.
- **Timer (only with `INTR_TIMER_EN`).** Write TIMER_CMP = 10, ENABLE = 1.
  - pending[0] is set when the counter reaches 10.
  - `interrupt` = 4'b0001 at that point plus 1 cycle.
  - Address 3 reads back 10.
